// File: rtl/delay_rv_if.sv
// Valid/ready handshake bundle for delay_rv; DELAY_RV_COUNT_EN adds the occupancy count.
interface delay_rv_if #(
    parameter int unsigned CYCLES = 4,
    parameter int unsigned WIDTH  = 8
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
`ifdef DELAY_RV_COUNT_EN
    logic [$clog2(CYCLES+1)-1:0] count;

    modport master (
        output flush, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, count
    );
    modport slave (
        input  flush, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, count
    );
`else
    modport master (
        output flush, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );
    modport slave (
        input  flush, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
`endif
endinterface

// File: rtl/delay_rv.sv
// CYCLES-deep elastic delay line with per-stage valid bits and bubble collapsing.
// Define DELAY_RV_COUNT_EN to add the registered occupancy output bus.count.
module delay_rv #(
    parameter int unsigned      CYCLES   = 4,
    parameter int unsigned      WIDTH    = 8,
    parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
    input logic     clk,
    input logic     rst,
    delay_rv_if.slave bus
);

    if (CYCLES == 0) begin : g_bad_cycles
        $error("delay_rv: CYCLES must be greater than 0");
    end

    logic [CYCLES-1:0] valid_q;
    logic [CYCLES-1:0] ld;
    logic [WIDTH-1:0]  data_q [CYCLES];

    // A stage may load if it is empty or the stage ahead of it is loading.
    always_comb begin
        logic l;
        ld = '0;
        l  = !valid_q[CYCLES-1] || bus.out_ready;
        ld[CYCLES-1] = l;
        for (int i = int'(CYCLES) - 2; i >= 0; i--) begin
            l     = !valid_q[i] || l;
            ld[i] = l;
        end
    end

    assign bus.in_ready  = ld[0] && !bus.flush;
    assign bus.out_valid = valid_q[CYCLES-1];
    assign bus.out_data  = data_q[CYCLES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < int'(CYCLES); i++) begin
                data_q[i] <= INIT_VAL;
            end
        end else if (bus.flush) begin
            valid_q <= '0;
        end else begin
            if (ld[0]) begin
                valid_q[0] <= bus.in_valid;
                data_q[0]  <= bus.in_data;
            end
            for (int i = 1; i < int'(CYCLES); i++) begin
                if (ld[i]) begin
                    valid_q[i] <= valid_q[i-1];
                    data_q[i]  <= data_q[i-1];
                end
            end
        end
    end

`ifdef DELAY_RV_COUNT_EN
    localparam int unsigned CW = $clog2(CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(CYCLES);

    logic [CW-1:0] count_q;
    logic          in_acc;
    logic          out_acc;

    assign in_acc    = bus.in_valid && bus.in_ready;
    assign out_acc   = bus.out_valid && bus.out_ready;
    assign bus.count = count_q;

    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            count_q <= '0;
        end else if (in_acc && !out_acc) begin
            count_q <= count_q + 1'b1;
        end else if (out_acc && !in_acc) begin
            count_q <= count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !bus.flush) begin
            assert (!(in_acc && !out_acc && count_q == CNT_MAX))
                else $error("delay_rv: count overflow");
            assert (!(out_acc && !in_acc && count_q == '0))
                else $error("delay_rv: count underflow");
        end
    end
`endif

endmodule

// File: tb/tb_delay_rv.sv
// Scoreboard bench for delay_rv: CYCLES=4, WIDTH=8, INIT_VAL=0x5A.
module tb_delay_rv;
    localparam int unsigned CYCLES = 4;
    localparam int unsigned WIDTH  = 8;
    localparam logic [7:0]  INIT   = 8'h5A;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    delay_rv_if #(.CYCLES(CYCLES), .WIDTH(WIDTH)) bus ();

    delay_rv #(
        .CYCLES  (CYCLES),
        .WIDTH   (WIDTH),
        .INIT_VAL(INIT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit mon_en  = 1'b0;
    bit lat_chk = 1'b0;
    logic [7:0] exp_q   [$];
    int         stamp_q [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Transfers seen at the falling edge happen on the following rising edge.
    always @(negedge clk) begin
        if (mon_en) begin
`ifdef DELAY_RV_COUNT_EN
            chk("count", 32'(bus.count), 32'(exp_q.size()));
`endif
            if (rst) begin
                exp_q.delete();
                stamp_q.delete();
            end else begin
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("out_when_empty", 32'(bus.out_valid), 32'd0);
                    end else begin
                        logic [7:0] e;
                        int         s;
                        e = exp_q.pop_front();
                        s = stamp_q.pop_front();
                        chk("out_data", 32'(bus.out_data), 32'(e));
                        if (lat_chk) chk("latency", 32'(cyc - s), 32'(CYCLES));
                    end
                end
                if (bus.in_valid && bus.in_ready) begin
                    exp_q.push_back(bus.in_data);
                    stamp_q.push_back(cyc);
                end
                if (bus.flush) begin
                    exp_q.delete();
                    stamp_q.delete();
                end
            end
        end
    end

    task automatic drive(input logic v, input logic [7:0] d, input logic ordy, input logic fl);
        @(posedge clk);
        #1;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = ordy;
        bus.flush     = fl;
        @(negedge clk);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 1'b1, 1'b0);
        chk("drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.out_ready = 1'b0;
        bus.flush     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data", 32'(bus.out_data), 32'(INIT));
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

        // Streaming at full rate, every word with nominal latency.
        lat_chk = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            drive(1'b1, 8'(i), 1'b1, 1'b0);
            chk("stream_in_ready", 32'(bus.in_ready), 32'd1);
        end
        drain(6);
        lat_chk = 1'b0;

        // Backpressure: four fill the pipe, the fifth waits.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0);
            chk("fill_in_ready", 32'(bus.in_ready), 32'd1);
        end
        drive(1'b1, 8'hA4, 1'b0, 1'b0);
        chk("full_in_ready", 32'(bus.in_ready), 32'd0);
        drive(1'b1, 8'hA4, 1'b0, 1'b0);
        chk("full_in_ready2", 32'(bus.in_ready), 32'd0);
        chk("full_out_valid", 32'(bus.out_valid), 32'd1);
        chk("full_out_data", 32'(bus.out_data), 32'hA0);
        drive(1'b1, 8'hA4, 1'b1, 1'b0);
        chk("full_pass_in_ready", 32'(bus.in_ready), 32'd1);
        drive(1'b1, 8'hA5, 1'b1, 1'b0);
        chk("full_pass_in_ready2", 32'(bus.in_ready), 32'd1);
        drain(8);

        // Bubble collapse under a stalled output.
        drive(1'b1, 8'h11, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        drive(1'b1, 8'h22, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive(1'b0, 8'h00, 1'b0, 1'b0);
        chk("bubble_in_ready", 32'(bus.in_ready), 32'd1);
        chk("bubble_out_data", 32'(bus.out_data), 32'h11);
        drive(1'b1, 8'h33, 1'b0, 1'b0);
        chk("bubble_free1", 32'(bus.in_ready), 32'd1);
        drive(1'b1, 8'h44, 1'b0, 1'b0);
        chk("bubble_free2", 32'(bus.in_ready), 32'd1);
        drive(1'b1, 8'h55, 1'b0, 1'b0);
        chk("bubble_full", 32'(bus.in_ready), 32'd0);
        drain(6);

        // Flush with three words in flight.
        for (int i = 0; i < 3; i++) drive(1'b1, 8'hB1 + 8'(i), 1'b0, 1'b0);
        drive(1'b1, 8'hBF, 1'b0, 1'b1);
        chk("flush_in_ready", 32'(bus.in_ready), 32'd0);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
        lat_chk = 1'b1;
        drive(1'b1, 8'hC1, 1'b1, 1'b0);
        drain(6);
        lat_chk = 1'b0;

        // Synchronous reset mid-stream drops everything in flight.
        for (int i = 0; i < 3; i++) drive(1'b1, 8'hD0 + 8'(i), 1'b1, 1'b0);
        @(posedge clk);
        #1;
        bus.in_data = 8'hD3;
        rst         = 1'b1;
        @(negedge clk);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_out_data", 32'(bus.out_data), 32'(INIT));
        chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
        drain(6);
        lat_chk = 1'b1;
        drive(1'b1, 8'hE1, 1'b1, 1'b0);
        drain(6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
